// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state encoding, instruction fields, ALU op codes and error codes for the MIPS control FSM
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    BOOT, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR,
    MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, JAL, JR, HALT
  } state_t;
  typedef enum logic [2:0] {CLS_IDLE, CLS_ADDR, CLS_EXEC_R, CLS_EXEC_I, CLS_BRANCH} cls_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;
  // FETCH and MEM_ADDR both compute an address with the adder
  function automatic cls_t state_class(input state_t s);
    return (s == FETCH || s == MEM_ADDR) ? CLS_ADDR :
           s == EXEC_R ? CLS_EXEC_R :
           s == EXEC_I ? CLS_EXEC_I :
           s == BRANCH ? CLS_BRANCH : CLS_IDLE;
  endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps the state class and instruction fields to the ALU operation and flags unknown instructions
module alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 3
) (
  input  logic [2:0]         cls,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  output logic [ALUOP_W-1:0] aluop,
  output logic               legal
);
  logic [2:0] r_op, op;
  logic       r_ok;
  always_comb begin
    r_op = ALU_ADD;
    r_ok = 1'b1;
    case (funct)
      FN_ADD:  r_op = ALU_ADD;
      FN_SUB:  r_op = ALU_SUB;
      FN_AND:  r_op = ALU_AND;
      FN_OR:   r_op = ALU_OR;
      FN_SLT:  r_op = ALU_SLT;
      FN_JR:   r_op = ALU_ADD;
      default: r_ok = 1'b0;
    endcase
  end
  assign legal = opcode == OP_R ? r_ok :
                 opcode inside {OP_LW, OP_SW, OP_ADDI, OP_SLTI, OP_BEQ, OP_J, OP_JAL};
  assign op = cls == CLS_EXEC_R ? r_op :
              cls == CLS_EXEC_I ? (opcode == OP_SLTI ? ALU_SLT : ALU_ADD) :
              cls == CLS_ADDR   ? ALU_ADD :
              cls == CLS_BRANCH ? ALU_SUB : ALU_AND;
  assign aluop = ALUOP_W'(op);
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS control FSM with memory-ready wait/timeout.
// Define ILLEGAL_TRAP_EN to halt on unknown instructions instead of treating them as NOPs.
module mc_controller
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int          ALUOP_W     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         opr,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               irwrite,
  output logic               iord,
  output logic               selreg,
  output logic               regdst,
  output logic               alusrc,
  output logic               memread,
  output logic               memwrite,
  output logic               pcsrc,
  output logic               jal,
  output logic               jr,
  output logic               jmp,
  output logic               regwrite,
  output logic               memtoreg,
  output logic [ALUOP_W-1:0] aluopration,
  output logic               halted,
  output logic [1:0]         err_code
);
  localparam int CNT_W = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT + 1) : 1;
`ifdef ILLEGAL_TRAP_EN
  localparam state_t ILL_NXT = HALT;
`else
  localparam state_t ILL_NXT = FETCH;
`endif
  state_t           state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       err, err_nxt;
  logic             legal, waiting, tmo;
  alu_decoder #(.ALUOP_W(ALUOP_W)) u_dec (
    .cls   (state_class(state)),
    .opcode(opcode),
    .funct (opr),
    .aluop (aluopration),
    .legal (legal)
  );
  assign waiting = state inside {FETCH, MEM_RD, MEM_WR};
  // a ready arriving on the final count still completes the access
  assign tmo = waiting && MEM_TIMEOUT != 0 && !mem_ready && (32'(cnt) + 32'd1 == MEM_TIMEOUT);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BOOT;
      cnt   <= '0;
      err   <= ERR_NONE;
    end else begin
      state <= nxt;
      cnt   <= nxt != state ? '0 : cnt + CNT_W'(!mem_ready);
      err   <= err_nxt;
    end
  end
  always_comb begin
    nxt     = state;
    err_nxt = err;
    case (state)
      BOOT:     nxt = FETCH;
      FETCH:    nxt = mem_ready ? DECODE : tmo ? HALT : FETCH;
      DECODE:   nxt = !legal ? ILL_NXT :
                      opcode == OP_R ? (opr == FN_JR ? JR : EXEC_R) :
                      (opcode == OP_LW || opcode == OP_SW) ? MEM_ADDR :
                      opcode == OP_BEQ ? BRANCH :
                      opcode == OP_J   ? JUMP :
                      opcode == OP_JAL ? JAL : EXEC_I;
      EXEC_R:   nxt = WB_R;
      EXEC_I:   nxt = WB_I;
      MEM_ADDR: nxt = opcode == OP_LW ? MEM_RD : MEM_WR;
      MEM_RD:   nxt = mem_ready ? MEM_WB : tmo ? HALT : MEM_RD;
      MEM_WR:   nxt = mem_ready ? FETCH : tmo ? HALT : MEM_WR;
      HALT:     nxt = HALT;
      default:  nxt = FETCH;
    endcase
    if (nxt == HALT && state != HALT) err_nxt = tmo ? ERR_TIMEOUT : ERR_ILLEGAL;
  end
  always_comb begin
    {pcwrite, irwrite, iord, selreg, regdst, alusrc, memread,
     memwrite, pcsrc, jal, jr, jmp, regwrite, memtoreg} = '0;
    case (state)
      FETCH:            begin memread = 1'b1; irwrite = mem_ready; pcwrite = mem_ready; end
      WB_R:             begin regdst = 1'b1; regwrite = 1'b1; end
      EXEC_I, MEM_ADDR: alusrc = 1'b1;
      WB_I:             regwrite = 1'b1;
      MEM_RD:           begin iord = 1'b1; memread = 1'b1; end
      MEM_WB:           begin memtoreg = 1'b1; regwrite = 1'b1; end
      MEM_WR:           begin iord = 1'b1; memwrite = 1'b1; end
      BRANCH:           begin pcsrc = 1'b1; pcwrite = opcode == OP_BEQ && zero; end
      JUMP:             begin jmp = 1'b1; pcwrite = 1'b1; end
      JAL:              begin jmp = 1'b1; jal = 1'b1; selreg = 1'b1; regwrite = 1'b1; pcwrite = 1'b1; end
      JR:               begin jmp = 1'b1; jr = 1'b1; pcwrite = 1'b1; end
      default:          ;
    endcase
  end
  assign halted   = state == HALT;
  assign err_code = err;
endmodule
